// File: rtl/ram_copy_engine_if.sv
// ---------------------------------------------------------------------------
// Isa / RamPort
// Purpose : Memory geometry constants and the RamPort bundle between a RAM
//           controller (initiator) and a single-port synchronous RAM.
// RamPort signals:
//   enable        controller -> RAM  access strobe
//   write_enable  controller -> RAM  1 = write, 0 = read (with enable)
//   address       controller -> RAM  word address
//   write_data    controller -> RAM  data written when write_enable=1
//   read_data     RAM -> controller  registered read data, valid the cycle
//                                    after an enable=1/write_enable=0 cycle
// ---------------------------------------------------------------------------
package Isa;
    localparam int MEMORY_DATA_WIDTH = 16;
    localparam int MEMORY_DEPTH      = 16;
endpackage

interface RamPort #(
    parameter int DataWidth    = Isa::MEMORY_DATA_WIDTH,
    parameter int AddressWidth = $clog2(Isa::MEMORY_DEPTH)
);
    logic                    enable;
    logic                    write_enable;
    logic [AddressWidth-1:0] address;
    logic [DataWidth-1:0]    write_data;
    logic [DataWidth-1:0]    read_data;

    modport Controller (
        output enable, write_enable, address, write_data,
        input  read_data
    );

    modport Ram (
        input  enable, write_enable, address, write_data,
        output read_data
    );
endinterface

// File: rtl/ram_copy_engine.sv
// ---------------------------------------------------------------------------
// ram_copy_engine
// Purpose : Copies i_length words from i_source to i_destination inside one
//           single-port RAM with memmove semantics (overlapping ranges are
//           copied in the direction that never clobbers unread source words).
// Ports   :
//   i_clock        clock, all logic on posedge
//   i_reset        synchronous active-high reset
//   i_start        copy request, sampled only while idle
//   i_source       first source word address
//   i_destination  first destination word address
//   i_length       word count, 0..Depth
//   o_busy         high from the cycle after acceptance through DONE/FAIL
//   o_done         one-cycle pulse, copy completed
//   o_error        one-cycle pulse, request rejected (range overflow)
//   ram_port       RamPort controller side
// ---------------------------------------------------------------------------
module ram_copy_engine #(
    parameter int DataWidth    = Isa::MEMORY_DATA_WIDTH,
    parameter int Depth        = Isa::MEMORY_DEPTH,
    parameter int AddressWidth = $clog2(Depth)
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_start,
    input  logic [AddressWidth-1:0] i_source,
    input  logic [AddressWidth-1:0] i_destination,
    input  logic [AddressWidth:0]   i_length,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_error,
    RamPort.Controller              ram_port
);

    localparam int SumWidth = AddressWidth + 2;
    localparam logic [SumWidth-1:0] DepthSum = SumWidth'(Depth);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_READ,
        S_WRITE,
        S_DONE,
        S_FAIL
    } state_t;

    state_t                  r_state, w_next_state;
    logic [AddressWidth-1:0] r_src, w_next_src;
    logic [AddressWidth-1:0] r_dst, w_next_dst;
    // Holds the latched length during CHECK, then counts remaining words.
    logic [AddressWidth:0]   r_count, w_next_count;
    logic                    r_descending, w_next_descending;

    logic                    r_busy, r_done, r_error;
    logic                    r_enable, r_write_enable;
    logic [AddressWidth-1:0] r_address;
    logic                    w_next_enable, w_next_write_enable;
    logic [AddressWidth-1:0] w_next_address;

    logic [SumWidth-1:0]     w_src_end, w_dst_end;
    logic                    w_overlap_down;
    logic [DataWidth-1:0]    w_write_data;

    assign w_src_end = SumWidth'(r_src) + SumWidth'(r_count);
    assign w_dst_end = SumWidth'(r_dst) + SumWidth'(r_count);
    // Destination starts inside the source range above its base: copy from
    // the top down so source words are read before being overwritten.
    assign w_overlap_down = (r_dst > r_src) && (SumWidth'(r_dst) < w_src_end);

    always_comb begin
        w_next_state      = r_state;
        w_next_src        = r_src;
        w_next_dst        = r_dst;
        w_next_count      = r_count;
        w_next_descending = r_descending;

        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next_state = S_CHECK;
                    w_next_src   = i_source;
                    w_next_dst   = i_destination;
                    w_next_count = i_length;
                end
            end
            S_CHECK: begin
                if ((w_src_end > DepthSum) || (w_dst_end > DepthSum)) begin
                    w_next_state = S_FAIL;
                end else if (r_count == '0) begin
                    w_next_state = S_DONE;
                end else begin
                    w_next_state      = S_READ;
                    w_next_descending = w_overlap_down;
                    if (w_overlap_down) begin
                        w_next_src = AddressWidth'(w_src_end - SumWidth'(1));
                        w_next_dst = AddressWidth'(w_dst_end - SumWidth'(1));
                    end
                end
            end
            S_READ: begin
                w_next_state = S_WRITE;
            end
            S_WRITE: begin
                w_next_count = r_count - (AddressWidth + 1)'(1);
                if (r_descending) begin
                    w_next_src = r_src - AddressWidth'(1);
                    w_next_dst = r_dst - AddressWidth'(1);
                end else begin
                    w_next_src = r_src + AddressWidth'(1);
                    w_next_dst = r_dst + AddressWidth'(1);
                end
                w_next_state = (r_count == (AddressWidth + 1)'(1)) ? S_DONE : S_READ;
            end
            S_DONE:  w_next_state = S_IDLE;
            S_FAIL:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase

        // RAM strobes are registered, so they are decoded from the state
        // being entered and appear in the same cycle as that state.
        w_next_enable       = (w_next_state == S_READ) || (w_next_state == S_WRITE);
        w_next_write_enable = (w_next_state == S_WRITE);
        if (w_next_state == S_READ) begin
            w_next_address = w_next_src;
        end else if (w_next_state == S_WRITE) begin
            w_next_address = w_next_dst;
        end else begin
            w_next_address = '0;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state        <= S_IDLE;
            r_src          <= '0;
            r_dst          <= '0;
            r_count        <= '0;
            r_descending   <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_error        <= 1'b0;
            r_enable       <= 1'b0;
            r_write_enable <= 1'b0;
            r_address      <= '0;
        end else begin
            r_state        <= w_next_state;
            r_src          <= w_next_src;
            r_dst          <= w_next_dst;
            r_count        <= w_next_count;
            r_descending   <= w_next_descending;
            r_busy         <= (w_next_state != S_IDLE);
            r_done         <= (w_next_state == S_DONE);
            r_error        <= (w_next_state == S_FAIL);
            r_enable       <= w_next_enable;
            r_write_enable <= w_next_write_enable;
            r_address      <= w_next_address;
        end
    end

    // The RAM's read register already holds the word from the preceding READ
    // throughout the WRITE cycle, so it is forwarded straight to write_data;
    // registering it again would cost a cycle per word.
    assign w_write_data = r_write_enable ? ram_port.read_data : '0;

    assign ram_port.enable       = r_enable;
    assign ram_port.write_enable = r_write_enable;
    assign ram_port.address      = r_address;
    assign ram_port.write_data   = w_write_data;

    assign o_busy  = r_busy;
    assign o_done  = r_done;
    assign o_error = r_error;

endmodule

// File: tb/tb_ram_copy_engine.sv
// ---------------------------------------------------------------------------
// tb_ram_copy_engine
// Purpose : Directed and randomized bench for ram_copy_engine. Holds a
//           synchronous RAM model on the RamPort and predicts results with a
//           word-level memmove reference and cycle-count rules.
// ---------------------------------------------------------------------------
module tb_ram_copy_engine;

    localparam int DW    = 16;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [AW:0]   len;
    logic          busy;
    logic          done;
    logic          error;

    logic [DW-1:0] mem      [DEPTH];
    logic [DW-1:0] init_mem [DEPTH];
    logic          load;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    RamPort #(.DataWidth(DW), .AddressWidth(AW)) ram_if ();

    ram_copy_engine #(.DataWidth(DW), .Depth(DEPTH)) dut (
        .i_clock       (clk),
        .i_reset       (rst),
        .i_start       (start),
        .i_source      (src),
        .i_destination (dst),
        .i_length      (len),
        .o_busy        (busy),
        .o_done        (done),
        .o_error       (error),
        .ram_port      (ram_if)
    );

    // Single-port synchronous RAM, registered read; bench preload via load.
    always @(posedge clk) begin
        if (load) begin
            mem <= init_mem;
        end else if (ram_if.enable) begin
            if (ram_if.write_enable) mem[ram_if.address] <= ram_if.write_data;
            else                     ram_if.read_data <= mem[ram_if.address];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_mem();
        @(negedge clk) load = 1'b1;
        @(negedge clk) load = 1'b0;
    endtask

    task automatic fill_random();
        for (int i = 0; i < DEPTH; i++) init_mem[i] = DW'($urandom);
    endtask

    // Issues one request and checks pulses, busy profile, RAM traffic and
    // final RAM contents. restart_c / reset_c: cycle in which an extra start
    // or a reset is applied (0 = none). Cycle 0 is the accepting cycle.
    task automatic run_copy(input string tag, input int s, input int d, input int l,
                            input int restart_c, input int reset_c);
        logic [DW-1:0] old [DEPTH];
        logic [DW-1:0] exp [DEPTH];
        bit err, desc;
        int end_c, last_c, exp_done, exp_err, exp_en, exp_wr, idx;
        int done_n, done_c, err_n, err_c, en_n, wr_n, busy_bad;

        old    = mem;
        exp    = mem;
        err    = (s + l > DEPTH) || (d + l > DEPTH);
        desc   = (d > s) && (d < s + l);
        end_c  = (err || l == 0) ? 2 : 2 * l + 2;
        last_c = (reset_c > 0) ? reset_c : end_c;
        exp_done = (reset_c == 0 && !err) ? 1 : 0;
        exp_err  = (reset_c == 0 && err) ? 1 : 0;
        exp_wr   = 0;
        if (!err) begin
            for (int k = 0; k < l; k++) begin
                if (reset_c == 0 || 2 * k + 3 <= reset_c) begin
                    idx = desc ? (l - 1 - k) : k;
                    exp[d + idx] = old[s + idx];
                    exp_wr++;
                end
            end
        end
        exp_en = err ? 0 : ((reset_c > 0 && reset_c - 1 < 2 * l) ? reset_c - 1 : 2 * l);

        done_n = 0; done_c = -1; err_n = 0; err_c = -1;
        en_n = 0; wr_n = 0; busy_bad = 0;

        @(negedge clk);
        src = AW'(s); dst = AW'(d); len = (AW + 1)'(l); start = 1'b1;
        for (int c = 1; c <= last_c + 4; c++) begin
            @(negedge clk);
            start = 1'b0;
            rst   = 1'b0;
            if (busy !== (c <= last_c)) busy_bad++;
            if (done  === 1'b1) begin done_n++; done_c = c; end
            if (error === 1'b1) begin err_n++;  err_c  = c; end
            if (ram_if.enable === 1'b1) en_n++;
            if (ram_if.enable === 1'b1 && ram_if.write_enable === 1'b1) wr_n++;
            if (reset_c > 0 && c == reset_c + 1) begin
                chk({tag, " post_reset_busy"},   busy, 0);
                chk({tag, " post_reset_enable"}, ram_if.enable, 0);
                chk({tag, " post_reset_addr"},   ram_if.address, 0);
            end
            if (c == restart_c) begin
                start = 1'b1; src = AW'(1); dst = AW'(15); len = (AW + 1)'(1);
            end
            if (c == reset_c) rst = 1'b1;
        end

        chk({tag, " done_count"},  done_n, exp_done);
        if (exp_done == 1) chk({tag, " done_cycle"}, done_c, end_c);
        chk({tag, " error_count"}, err_n, exp_err);
        if (exp_err == 1) chk({tag, " error_cycle"}, err_c, end_c);
        chk({tag, " busy_profile_bad_cycles"}, busy_bad, 0);
        chk({tag, " enable_cycles"}, en_n, exp_en);
        chk({tag, " write_cycles"},  wr_n, exp_wr);
        for (int i = 0; i < DEPTH; i++)
            chk($sformatf("%s mem[%0d]", tag, i), mem[i], exp[i]);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; src = '0; dst = '0; len = '0; load = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset busy",       busy, 0);
        chk("reset done",       done, 0);
        chk("reset error",      error, 0);
        chk("reset enable",     ram_if.enable, 0);
        chk("reset write_en",   ram_if.write_enable, 0);
        chk("reset address",    ram_if.address, 0);
        chk("reset write_data", ram_if.write_data, 0);
        rst = 1'b0;

        // Basic non-overlapping copy.
        fill_random();
        init_mem[0] = 16'hA0A0; init_mem[1] = 16'hB1B1;
        init_mem[2] = 16'hC2C2; init_mem[3] = 16'hD3D3;
        load_mem();
        run_copy("basic", 0, 8, 4, 0, 0);

        // Overlap in both directions.
        fill_random();
        for (int i = 0; i < 4; i++) init_mem[i] = DW'(i + 1);
        load_mem();
        run_copy("overlap_up", 0, 2, 4, 0, 0);
        run_copy("overlap_down", 2, 0, 4, 0, 0);

        // Zero length and range rejection.
        run_copy("len0", 5, 9, 0, 0, 0);
        run_copy("range_err", 14, 0, 3, 0, 0);
        run_copy("range_err_dst", 0, 13, 4, 0, 0);

        // Start while busy is ignored.
        fill_random();
        load_mem();
        run_copy("restart", 4, 12, 4, 4, 0);

        // Reset mid-copy, then a fresh copy.
        fill_random();
        load_mem();
        run_copy("reset_mid", 0, 8, 4, 0, 5);
        run_copy("after_reset", 0, 8, 4, 0, 0);

        // Same base and full range.
        run_copy("same_base", 3, 3, 5, 0, 0);
        fill_random();
        load_mem();
        run_copy("full", 0, 0, DEPTH, 0, 0);
        run_copy("full_limit", 15, 0, 1, 0, 0);

        // Randomized requests.
        for (int t = 0; t < 20; t++) begin
            int rs, rd, rl;
            fill_random();
            load_mem();
            rs = $urandom_range(0, DEPTH - 1);
            rd = $urandom_range(0, DEPTH - 1);
            rl = $urandom_range(0, DEPTH);
            if ($urandom_range(0, 2) == 0 && rs + 6 < DEPTH) begin
                rd = rs + $urandom_range(1, 3);
                rl = $urandom_range(2, 6);
            end
            run_copy($sformatf("rand%0d", t), rs, rd, rl, 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
